sprite_mixer: RTL and testbench
===============================

Name: sprite_mixer

Overview:
Parametrised N-channel sprite compositor and successor to the single-sprite draw stage. It overlays up to N_SPRITES fixed-size sprites, each from its own synchronous ROM, onto the background vga_if stream.
- Per-sprite position, enable and animation-frame base are latched once per frame, so there is no mid-frame tearing.
- Colour-key transparency; lower sprite index is drawn on top.
- Per-frame pixel-accurate collision flags (e.g. Tom catches Jerry).
- Sits between draw_bg and the VGA output pins in top_vga.

Parameters:
N_SPRITES, 2, number of sprite channels (1..8)
SPR_W, 64, sprite width in pixels, power of two
SPR_H, 64, sprite height in pixels
POS_W, 11, width of sprite x/y coordinates, matches vga_if hcount/vcount
ADDR_W, 20, ROM address width per channel
KEY_RGB, 12'hF0F, transparent colour key

Ports:
clk  input  1  pixel clock
rst  input  1  synchronous reset, active-low
in  vga_if  -  background stream (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb)
out  vga_if  -  composited stream
spr_x  input  N_SPRITES x POS_W  sprite top-left x
spr_y  input  N_SPRITES x POS_W  sprite top-left y
spr_en  input  N_SPRITES  sprite visible
spr_base  input  N_SPRITES x ADDR_W  ROM base of current animation frame
rom_addr  output  N_SPRITES x ADDR_W  ROM read address, registered
rom_data  input  N_SPRITES x 12  ROM read data, 1-cycle latency after rom_addr
collide  output  N_SPRITES  bit i = sprite i overlapped another sprite last frame
collide_valid  output  1  1-cycle pulse when collide updates

Behaviour:
- Reset (rst==0 at clk edge):
  - Outputs: all out fields, rom_addr, collide and collide_valid go to 0.
  - State: shadow regs (x, y, base) go to 0, shadow en to 0, and the collision accumulator clears.
- Frame latch:
  - Trigger: first cycle of in.vblnk rising edge (in.vblnk==1 and previous value 0).
  - Action: shadow x/y/en/base <= spr_* inputs.
  - Input changes at any other time do not affect the current frame.
- Stage 1 (registered, per sprite i):
  - dx = hcount - sx, dy = vcount - sy, each computed in POS_W+1 bits, so negative values are misses.
  - hit_i = en_i and dx<SPR_W and dy<SPR_H.
  - rom_addr_i = base_i + dy*SPR_W + dx, truncated to ADDR_W. Multiply is a shift.
  - rom_addr_i is held at its previous value when hit_i is 0.
  - Timing fields are delayed alongside.
- Stage 2: rom_data valid; hit and timing fields delayed one more cycle.
- Stage 3 (output register):
  - opaque_i = hit_i and rom_data_i != KEY_RGB.
  - out.rgb = rom_data of the lowest i with opaque_i; otherwise the delayed background rgb.
  - Blanking (delayed hblnk or vblnk) forces out.rgb = 12'h000.
- Latency: every out field equals the corresponding in field delayed exactly 3 clk cycles. Pipeline is fully streaming with no stalls.
- Clipping: sprites partially beyond the active area show only their visible part. There is no horizontal/vertical wrap.
- Collision:
  - Detection: during active pixels at stage 3, if two or more opaque_i are set, acc[i] |= opaque_i for each such i.
  - Publish: on the stage-3 vblnk rising edge, collide <= acc, collide_valid pulses 1 cycle, and acc clears in the same cycle.
  - collide holds until the next publish.
- Reset mid-frame:
  - out is 0 for 3 cycles, then background passes through.
  - No sprite is drawn until the first frame latch after reset.
  - The first collide_valid after reset reports the partial frame.
- A disabled sprite never hits, collides or drives a changing rom_addr.

Decomposition:
- Package sprite_pkg:
  - rgb_t (12-bit)
  - KEY_RGB default
  - MAX_SPRITES = 8
  - spr_pos_t (POS_W-bit typedef)
- Sub-module sprite_hit_addr:
  - One sprite's stage-1 hit test and address generation.
  - Instantiated N_SPRITES times in a generate loop.
- sprite_mixer holds:
  - shadow regs
  - delay lines
  - priority mux
  - collision accumulator

Test Plan:
- Latency: N=2, both disabled, in.rgb ramp -> out equals in delayed exactly 3 cycles on all fields; out.rgb=0 during blanking.
- Priority: sprite0 at (100,100), sprite1 at (120,100), both opaque ROMs 12'h0F0 and 12'h00F -> pixel (130,110) = 12'h0F0; (170,110) = 12'h00F; (99,110) = background.
- Transparency: sprite0 ROM word at dx=5,dy=0 = 12'hF0F, sprite1 beneath -> that pixel shows sprite1 colour; rom_addr0 = base0+5 when hcount=105.
- Frame latch: change spr_x0 from 100 to 200 at vcount=300 -> remainder of frame still at 100; next frame at 200.
- Collision: overlapping opaque sprites for one frame -> collide=2'b11 with a single collide_valid pulse at the next vblnk. Sprites moved apart -> collide=2'b00 the following frame.
- Reset: assert rst=0 for 2 cycles at hcount=400 -> all outputs 0. After release: background only until the next vblnk latch; sprites reappear the frame after.

Source files
------------

// File: rtl/sprite_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
// Shared types and constants for the sprite compositor.
//   rgb_t        : 12-bit 4:4:4 pixel colour
//   spr_pos_t    : screen coordinate type, same width as hcount/vcount
//   KEY_RGB_DEF  : default transparent colour key
//   MAX_SPRITES  : upper bound on the number of sprite channels
//   multi_hot()  : true when two or more bits of a channel mask are set
// ---------------------------------------------------------------------------
package sprite_pkg;

    localparam int RGB_W       = 12;
    localparam int POS_W_DEF   = 11;
    localparam int MAX_SPRITES = 8;

    typedef logic [RGB_W-1:0]     rgb_t;
    typedef logic [POS_W_DEF-1:0] spr_pos_t;

    localparam rgb_t KEY_RGB_DEF = 12'hF0F;

    // Clearing the lowest set bit leaves something only if another bit was set.
    function automatic logic multi_hot(input logic [MAX_SPRITES-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/sprite_hit_addr.sv
// ---------------------------------------------------------------------------
// sprite_hit_addr
// Stage-1 hit test and ROM address generation for one sprite channel.
// Ports:
//   i_clk, i_rst          : pixel clock, synchronous active-low reset
//   i_hcount, i_vcount    : current pixel position
//   i_sx, i_sy, i_en      : latched sprite top-left corner and enable
//   i_base                : latched ROM base of the current animation frame
//   o_hit                 : registered, pixel lies inside an enabled sprite
//   o_rom_addr            : registered ROM address, held while not hitting
// ---------------------------------------------------------------------------
module sprite_hit_addr
    import sprite_pkg::*;
#(
    parameter int POS_W  = 11,
    parameter int SPR_W  = 64,
    parameter int SPR_H  = 64,
    parameter int ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [POS_W-1:0]  i_hcount,
    input  logic [POS_W-1:0]  i_vcount,
    input  logic [POS_W-1:0]  i_sx,
    input  logic [POS_W-1:0]  i_sy,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_base,
    output logic              o_hit,
    output logic [ADDR_W-1:0] o_rom_addr
);

    localparam int SHIFT = $clog2(SPR_W);

    logic [POS_W:0]    w_dx;
    logic [POS_W:0]    w_dy;
    logic              w_hit;
    logic [ADDR_W-1:0] w_addr;
    logic              r_hit_p1;
    logic [ADDR_W-1:0] r_addr_p1;

    // One extra bit: a pixel left of / above the sprite wraps to a large
    // unsigned value and so fails the range check, giving clipping for free.
    assign w_dx   = {1'b0, i_hcount} - {1'b0, i_sx};
    assign w_dy   = {1'b0, i_vcount} - {1'b0, i_sy};
    assign w_hit  = i_en && (w_dx < (POS_W+1)'(SPR_W)) && (w_dy < (POS_W+1)'(SPR_H));
    assign w_addr = i_base + (ADDR_W'(w_dy) << SHIFT) + ADDR_W'(w_dx);

    // ---- stage 1 ----
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_hit_p1  <= 1'b0;
            r_addr_p1 <= '0;
        end else begin
            r_hit_p1 <= w_hit;
            if (w_hit)
                r_addr_p1 <= w_addr;
        end
    end

    assign o_hit      = r_hit_p1;
    assign o_rom_addr = r_addr_p1;

endmodule

// File: rtl/sprite_mixer.sv
// ---------------------------------------------------------------------------
// sprite_mixer
// N-channel sprite compositor overlaying fixed-size ROM sprites on a VGA
// background stream; output is the input delayed exactly 3 clocks.
// Ports:
//   i_clk, i_rst                     : pixel clock, sync active-low reset
//   i_hcount..i_rgb                  : background stream
//   o_hcount..o_rgb                  : composited stream
//   i_spr_x/_y/_en/_base             : per-sprite controls, latched at vblank
//   o_rom_addr / i_rom_data          : per-sprite ROM port, 1-cycle latency
//   o_collide / o_collide_valid      : per-frame collision flags and pulse
// ---------------------------------------------------------------------------
module sprite_mixer
    import sprite_pkg::*;
#(
    parameter int   N_SPRITES = 2,
    parameter int   SPR_W     = 64,
    parameter int   SPR_H     = 64,
    parameter int   POS_W     = 11,
    parameter int   ADDR_W    = 20,
    parameter rgb_t KEY_RGB   = KEY_RGB_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [POS_W-1:0]              i_hcount,
    input  logic [POS_W-1:0]              i_vcount,
    input  logic                          i_hsync,
    input  logic                          i_vsync,
    input  logic                          i_hblnk,
    input  logic                          i_vblnk,
    input  logic [11:0]                   i_rgb,
    output logic [POS_W-1:0]              o_hcount,
    output logic [POS_W-1:0]              o_vcount,
    output logic                          o_hsync,
    output logic                          o_vsync,
    output logic                          o_hblnk,
    output logic                          o_vblnk,
    output logic [11:0]                   o_rgb,
    input  logic [N_SPRITES*POS_W-1:0]    i_spr_x,
    input  logic [N_SPRITES*POS_W-1:0]    i_spr_y,
    input  logic [N_SPRITES-1:0]          i_spr_en,
    input  logic [N_SPRITES*ADDR_W-1:0]   i_spr_base,
    output logic [N_SPRITES*ADDR_W-1:0]   o_rom_addr,
    input  logic [N_SPRITES*12-1:0]       i_rom_data,
    output logic [N_SPRITES-1:0]          o_collide,
    output logic                          o_collide_valid
);

    localparam int TW = 2*POS_W + 4 + 12;

    logic                        r_vblnk_prev;
    logic [N_SPRITES*POS_W-1:0]  r_sh_x;
    logic [N_SPRITES*POS_W-1:0]  r_sh_y;
    logic [N_SPRITES-1:0]        r_sh_en;
    logic [N_SPRITES*ADDR_W-1:0] r_sh_base;

    logic [TW-1:0]               w_tim_p0;
    logic [TW-1:0]               r_tim_p1;
    logic [TW-1:0]               r_tim_p2;
    logic [N_SPRITES-1:0]        w_hit_p1;
    logic [N_SPRITES-1:0]        r_hit_p2;

    logic [POS_W-1:0]            w_hc_p2;
    logic [POS_W-1:0]            w_vc_p2;
    logic                        w_hs_p2, w_vs_p2, w_hb_p2, w_vb_p2;
    logic [11:0]                 w_bg_p2;
    logic [N_SPRITES-1:0]        w_opaque;
    rgb_t                        w_rgb_p2;
    logic                        w_active;
    logic                        w_pub;

    logic [POS_W-1:0]            r_hc_o, r_vc_o;
    logic                        r_hs_o, r_vs_o, r_hb_o, r_vb_o;
    rgb_t                        r_rgb_o;
    logic [N_SPRITES-1:0]        r_acc;
    logic [N_SPRITES-1:0]        r_collide;
    logic                        r_collide_vld;

    // Sprite parameters only change on the first cycle of vblank.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_vblnk_prev <= 1'b0;
            r_sh_x       <= '0;
            r_sh_y       <= '0;
            r_sh_en      <= '0;
            r_sh_base    <= '0;
        end else begin
            r_vblnk_prev <= i_vblnk;
            if (i_vblnk && !r_vblnk_prev) begin
                r_sh_x    <= i_spr_x;
                r_sh_y    <= i_spr_y;
                r_sh_en   <= i_spr_en;
                r_sh_base <= i_spr_base;
            end
        end
    end

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_spr
        sprite_hit_addr #(
            .POS_W  (POS_W),
            .SPR_W  (SPR_W),
            .SPR_H  (SPR_H),
            .ADDR_W (ADDR_W)
        ) u_hit (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_hcount   (i_hcount),
            .i_vcount   (i_vcount),
            .i_sx       (r_sh_x[g*POS_W +: POS_W]),
            .i_sy       (r_sh_y[g*POS_W +: POS_W]),
            .i_en       (r_sh_en[g]),
            .i_base     (r_sh_base[g*ADDR_W +: ADDR_W]),
            .o_hit      (w_hit_p1[g]),
            .o_rom_addr (o_rom_addr[g*ADDR_W +: ADDR_W])
        );
    end

    assign w_tim_p0 = {i_hcount, i_vcount, i_hsync, i_vsync, i_hblnk, i_vblnk, i_rgb};

    // ---- stage 1 / stage 2 ----
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_tim_p1 <= '0;
            r_tim_p2 <= '0;
            r_hit_p2 <= '0;
        end else begin
            r_tim_p1 <= w_tim_p0;
            r_tim_p2 <= r_tim_p1;
            r_hit_p2 <= w_hit_p1;
        end
    end

    assign {w_hc_p2, w_vc_p2, w_hs_p2, w_vs_p2, w_hb_p2, w_vb_p2, w_bg_p2} = r_tim_p2;

    // Walk from the highest index down so the lowest opaque sprite wins.
    always_comb begin
        w_opaque = '0;
        w_rgb_p2 = w_bg_p2;
        for (int i = N_SPRITES-1; i >= 0; i--) begin
            w_opaque[i] = r_hit_p2[i] && (i_rom_data[i*12 +: 12] != KEY_RGB);
            if (w_opaque[i])
                w_rgb_p2 = i_rom_data[i*12 +: 12];
        end
        if (w_hb_p2 || w_vb_p2)
            w_rgb_p2 = '0;
    end

    assign w_active = !(w_hb_p2 || w_vb_p2);
    assign w_pub    = w_vb_p2 && !r_vb_o;

    // ---- stage 3 ----
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_hc_o  <= '0;
            r_vc_o  <= '0;
            r_hs_o  <= 1'b0;
            r_vs_o  <= 1'b0;
            r_hb_o  <= 1'b0;
            r_vb_o  <= 1'b0;
            r_rgb_o <= '0;
        end else begin
            r_hc_o  <= w_hc_p2;
            r_vc_o  <= w_vc_p2;
            r_hs_o  <= w_hs_p2;
            r_vs_o  <= w_vs_p2;
            r_hb_o  <= w_hb_p2;
            r_vb_o  <= w_vb_p2;
            r_rgb_o <= w_rgb_p2;
        end
    end

    // Publishing happens in vblank, so it never collides with accumulation.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_acc         <= '0;
            r_collide     <= '0;
            r_collide_vld <= 1'b0;
        end else begin
            r_collide_vld <= w_pub;
            if (w_pub) begin
                r_collide <= r_acc;
                r_acc     <= '0;
            end else if (w_active && multi_hot(MAX_SPRITES'(w_opaque))) begin
                r_acc <= r_acc | w_opaque;
            end
        end
    end

    assign o_hcount        = r_hc_o;
    assign o_vcount        = r_vc_o;
    assign o_hsync         = r_hs_o;
    assign o_vsync         = r_vs_o;
    assign o_hblnk         = r_hb_o;
    assign o_vblnk         = r_vb_o;
    assign o_rgb           = r_rgb_o;
    assign o_collide       = r_collide;
    assign o_collide_valid = r_collide_vld;

endmodule

// File: tb/tb_sprite_mixer.sv
// ---------------------------------------------------------------------------
// tb_sprite_mixer
// Directed bench for sprite_mixer with N_SPRITES=2, 64x64 sprites.
// Sprite 0 ROM: 12'h0F0 everywhere except address 1005 (colour key).
// Sprite 1 ROM: 12'h00F everywhere.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sprite_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount, vcount;
    logic        hsync, vsync, hblnk, vblnk;
    logic [11:0] rgb;
    logic [10:0] o_hcount, o_vcount;
    logic        o_hsync, o_vsync, o_hblnk, o_vblnk;
    logic [11:0] o_rgb;
    logic [21:0] spr_x, spr_y;
    logic [1:0]  spr_en;
    logic [39:0] spr_base;
    logic [39:0] rom_addr;
    logic [23:0] rom_data;
    logic [1:0]  collide;
    logic        collide_valid;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses;

    sprite_mixer dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_hcount        (hcount),
        .i_vcount        (vcount),
        .i_hsync         (hsync),
        .i_vsync         (vsync),
        .i_hblnk         (hblnk),
        .i_vblnk         (vblnk),
        .i_rgb           (rgb),
        .o_hcount        (o_hcount),
        .o_vcount        (o_vcount),
        .o_hsync         (o_hsync),
        .o_vsync         (o_vsync),
        .o_hblnk         (o_hblnk),
        .o_vblnk         (o_vblnk),
        .o_rgb           (o_rgb),
        .i_spr_x         (spr_x),
        .i_spr_y         (spr_y),
        .i_spr_en        (spr_en),
        .i_spr_base      (spr_base),
        .o_rom_addr      (rom_addr),
        .i_rom_data      (rom_data),
        .o_collide       (collide),
        .o_collide_valid (collide_valid)
    );

    always #5 clk = ~clk;

    // Synchronous sprite ROMs, one cycle read latency.
    always @(posedge clk) begin
        rom_data[11:0]  <= (rom_addr[19:0] == 20'd1005) ? 12'hF0F : 12'h0F0;
        rom_data[23:12] <= 12'h00F;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int h, input int v, input logic hb, input logic vb,
                         input logic [11:0] c);
        hcount = 11'(h);
        vcount = 11'(v);
        hsync  = 1'b0;
        vsync  = 1'b0;
        hblnk  = hb;
        vblnk  = vb;
        rgb    = c;
    endtask

    // One active pixel followed by two blanked fillers; result is on out after the third edge.
    task automatic probe(input int h, input int v, input logic [11:0] exp, input string tag);
        drive(h, v, 1'b0, 1'b0, 12'h555);
        tick();
        drive(h, v, 1'b1, 1'b0, 12'h555);
        tick();
        tick();
        chk(tag, 64'(o_rgb), 64'(exp));
    endtask

    // Vblank pulse: latches sprite inputs and (3 cycles later) publishes collisions.
    task automatic vsync_pulse(output int np);
        np = 0;
        drive(0, 600, 1'b1, 1'b1, 12'h000);
        tick();
        if (collide_valid) np++;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1'b1, 1'b0, 12'h000);
            tick();
            if (collide_valid) np++;
        end
    endtask

    initial begin
        logic [37:0] exp_tim;
        logic [11:0] exp_rgb;
        int          j;

        spr_x    = '0;
        spr_y    = '0;
        spr_en   = 2'b00;
        spr_base = '0;
        drive(400, 110, 1'b0, 1'b0, 12'h555);
        hsync = 1'b1;
        vsync = 1'b1;

        // Reset state
        rst = 1'b0;
        tick(); tick(); tick();
        chk("reset_out", {26'd0, o_hcount, o_vcount, o_hsync, o_vsync, o_hblnk, o_vblnk, o_rgb}, 64'd0);
        chk("reset_rom_addr", 64'(rom_addr), 64'd0);
        chk("reset_collide", {61'd0, collide, collide_valid}, 64'd0);
        rst = 1'b1;

        // Latency: sprites disabled, all fields delayed by 3 cycles, blanking forces black
        for (int k = 0; k < 10; k++) begin
            hcount = 11'(10 + k);
            vcount = 11'd20;
            hsync  = k[0];
            vsync  = k[1];
            hblnk  = (k == 5);
            vblnk  = 1'b0;
            rgb    = 12'(256 + k);
            tick();
            if (k >= 2) begin
                j = k - 2;
                exp_rgb = (j == 5) ? 12'h000 : 12'(256 + j);
                exp_tim = {11'(10 + j), 11'd20, j[0], j[1], (j == 5), 1'b0, exp_rgb};
                chk("latency", 64'({o_hcount, o_vcount, o_hsync, o_vsync, o_hblnk, o_vblnk, o_rgb}),
                    64'(exp_tim));
            end
        end

        // Frame A: sprite0 at (100,100), sprite1 at (120,100)
        spr_x    = {11'd120, 11'd100};
        spr_y    = {11'd100, 11'd100};
        spr_en   = 2'b11;
        spr_base = {20'd5000, 20'd1000};
        vsync_pulse(pulses);
        chk("pulse_after_latency", 64'(pulses), 64'd1);
        chk("collide_after_latency", 64'(collide), 64'd0);

        probe(130, 110, 12'h0F0, "prio_overlap");
        probe(170, 110, 12'h00F, "prio_s1_only");
        probe(99, 110, 12'h555, "left_of_s0");

        drive(105, 100, 1'b0, 1'b0, 12'h555);
        tick();
        chk("rom_addr0_dx5", 64'(rom_addr[19:0]), 64'd1005);
        drive(105, 100, 1'b1, 1'b0, 12'h555);
        tick();
        tick();
        chk("key_over_bg", 64'(o_rgb), 64'h555);

        probe(130, 163, 12'h0F0, "bottom_row_in");
        probe(130, 164, 12'h555, "bottom_row_out");
        probe(183, 110, 12'h00F, "right_col_in");
        probe(184, 110, 12'h555, "right_col_out");

        // Inputs moved mid-frame must not take effect yet
        spr_x = {11'd300, 11'd200};
        probe(130, 120, 12'h0F0, "latch_hold");

        vsync_pulse(pulses);
        chk("pulse_A", 64'(pulses), 64'd1);
        chk("collide_A", 64'(collide), 64'b11);
        chk("valid_low_A", 64'(collide_valid), 64'd0);

        // Frame B: sprites apart at x=200 and x=300
        probe(130, 110, 12'h555, "moved_old_pos");
        probe(210, 110, 12'h0F0, "moved_s0");
        probe(310, 110, 12'h00F, "moved_s1");
        spr_x = {11'd100, 11'd100};
        vsync_pulse(pulses);
        chk("pulse_B", 64'(pulses), 64'd1);
        chk("collide_B", 64'(collide), 64'b00);

        // Frame C: sprite1 directly beneath sprite0
        probe(105, 100, 12'h00F, "key_shows_s1");
        probe(106, 100, 12'h0F0, "s0_over_s1");

        // Reset mid-frame
        drive(400, 110, 1'b0, 1'b0, 12'h555);
        rst = 1'b0;
        tick();
        tick();
        chk("midrst_out", {26'd0, o_hcount, o_vcount, o_hsync, o_vsync, o_hblnk, o_vblnk, o_rgb}, 64'd0);
        chk("midrst_rom_addr", 64'(rom_addr), 64'd0);
        chk("midrst_collide", {61'd0, collide, collide_valid}, 64'd0);
        rst = 1'b1;
        probe(106, 100, 12'h555, "post_rst_bg");
        chk("post_rst_rom_addr", 64'(rom_addr), 64'd0);
        vsync_pulse(pulses);
        chk("pulse_post_rst", 64'(pulses), 64'd1);
        chk("collide_post_rst", 64'(collide), 64'b00);

        // Frame D: sprites back after the first latch
        probe(106, 100, 12'h0F0, "reappear_s0");
        probe(105, 100, 12'h00F, "reappear_s1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
